id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX) in the 5-stage MIPS pipeline.
- Captures the decode-stage sign/zero-extended immediate, register-file read data, register specifiers and control word.
- Detects load-use hazards and inserts bubbles, and supports hold (downstream stall) and flush (taken branch).
- Keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, datapath width (PC, register data, extended immediate)
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_pc4  input  DATA_W  PC+4 of ID instruction
id_rs_data  input  DATA_W  register file read port A
id_rt_data  input  DATA_W  register file read port B
id_imm_ext  input  DATA_W  extended immediate from decode extender
id_rs  input  5  rs specifier
id_rt  input  5  rt specifier
id_rd  input  5  rd specifier
id_uses_rt  input  1  instruction reads rt as a source (R-type, beq/bne, sw)
id_ALUCtrl  input  4  ALU operation code
id_ALUSrc, id_RegDst, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_Branch  input  1 each  control bits
flush  input  1  kill ID/EX contents (taken branch resolved downstream)
ex_stall  input  1  EX cannot accept; hold register
id_stall  output  1  hold PC and IF/ID register this cycle
ex_valid  output  1  EX holds a real instruction
ex_pc4, ex_rs_data, ex_rt_data, ex_imm_ext  output  DATA_W each  registered copies
ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers
ex_ALUCtrl  output  4  registered ALU code
ex_ALUSrc, ex_RegDst, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite, ex_Branch  output  1 each  registered control
bubble_cnt  output  CNT_W  bubbles inserted by load-use detection

Behaviour:
- Reset (rst_n=0 at a clk edge): every registered output is 0, including ex_valid, all control bits, all data fields and bubble_cnt.
- load_use (combinational): ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- id_stall = load_use | ex_stall. Combinational from registered state and ID inputs; it is not a function of flush.
- Per-edge update priority (highest first):
  1. reset
  2. flush: register becomes a bubble
  3. ex_stall: all fields hold
  4. load_use: register becomes a bubble; bubble_cnt += 1, saturating at all-ones
  5. otherwise load all ID fields; ex_valid <= id_valid
- Bubble: ex_valid=0; MemRead, MemWrite, RegWrite, Branch, MemtoReg = 0; ALUCtrl=0; data fields and specifiers = 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- id_valid=0 with no flush, stall or load-use loads the fields normally, but ex_valid=0 and RegWrite, MemRead, MemWrite, Branch are forced to 0.
- Flush together with ex_stall: flush wins, the register is cleared.
- Flush together with load_use: bubble is inserted, but bubble_cnt does not increment.
- ex_stall together with load_use: hold, no increment; load_use re-evaluates next cycle.
- Register $0: a load targeting $0 never triggers a stall.
- ex_imm_ext passes through unmodified; extension mode is decided upstream.

Test Plan:
- Reset: hold rst_n=0 two cycles with id_valid=1 driven -> all ex_* = 0, bubble_cnt=0, id_stall=0; release -> next edge loads ID fields.
- Load-use: lw $8 in EX (ex_MemRead=1, ex_rt=8) and add in ID with id_rs=8 -> id_stall=1, next edge ex_valid=0, ex_RegWrite=0, bubble_cnt=1; the cycle after, the add loads with id_imm_ext=0xFFFF_FFF6 passed through.
- rt-only hazard: ex_rt=9 loaded with MemRead, id_rt=9, id_uses_rt=0 -> no stall; repeat with id_uses_rt=1 -> stall. ex_rt=0 with id_rs=0 -> no stall.
- Flush priority: flush=1 and ex_stall=1 in the same cycle while EX holds sw -> next edge ex_valid=0, ex_MemWrite=0; flush together with load_use -> bubble_cnt unchanged.
- Hold: ex_stall=1 for 3 cycles with changing ID inputs -> ex_* constant, id_stall=1 throughout; on release the latest ID values load.
- Saturation: with CNT_W=4, force 20 load-use bubbles -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush,
// plus a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [3:0]        id_ALUCtrl,
  input  logic              id_ALUSrc,
  input  logic              id_RegDst,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_Branch,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_ALUCtrl,
  output logic              ex_ALUSrc,
  output logic              ex_RegDst,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_Branch,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] immExt;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [3:0]        aluCtrl;
    logic              aluSrc;
    logic              regDst;
    logic              memRead;
    logic              memWrite;
    logic              memtoReg;
    logic              regWrite;
    logic              branch;
  } exReg_t;

  exReg_t exQ;
  exReg_t idEntry;
  logic   loadUse;

  // A load into a nonzero register that the ID instruction reads must wait a cycle.
  always_comb begin
    loadUse = exQ.valid && exQ.memRead && (exQ.rt != REG_W'(0)) && id_valid &&
              ((exQ.rt == id_rs) || (id_uses_rt && (exQ.rt == id_rt)));
    id_stall = loadUse || ex_stall;
  end

  // Invalid ID slots still carry their fields but can have no side effects.
  always_comb begin
    idEntry          = '0;
    idEntry.valid    = id_valid;
    idEntry.pc4      = id_pc4;
    idEntry.rsData   = id_rs_data;
    idEntry.rtData   = id_rt_data;
    idEntry.immExt   = id_imm_ext;
    idEntry.rs       = id_rs;
    idEntry.rt       = id_rt;
    idEntry.rd       = id_rd;
    idEntry.aluCtrl  = id_ALUCtrl;
    idEntry.aluSrc   = id_ALUSrc;
    idEntry.regDst   = id_RegDst;
    idEntry.memtoReg = id_MemtoReg;
    idEntry.memRead  = id_MemRead && id_valid;
    idEntry.memWrite = id_MemWrite && id_valid;
    idEntry.regWrite = id_RegWrite && id_valid;
    idEntry.branch   = id_Branch && id_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exQ <= '0;
    end else if (flush) begin
      exQ <= '0;
    end else if (ex_stall) begin
      exQ <= exQ;
    end else if (loadUse) begin
      exQ <= '0;
    end else begin
      exQ <= idEntry;
    end
  end

  // Counts only bubbles that load-use detection actually inserted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!flush && !ex_stall && loadUse && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_valid    = exQ.valid;
  assign ex_pc4      = exQ.pc4;
  assign ex_rs_data  = exQ.rsData;
  assign ex_rt_data  = exQ.rtData;
  assign ex_imm_ext  = exQ.immExt;
  assign ex_rs       = exQ.rs;
  assign ex_rt       = exQ.rt;
  assign ex_rd       = exQ.rd;
  assign ex_ALUCtrl  = exQ.aluCtrl;
  assign ex_ALUSrc   = exQ.aluSrc;
  assign ex_RegDst   = exQ.regDst;
  assign ex_MemRead  = exQ.memRead;
  assign ex_MemWrite = exQ.memWrite;
  assign ex_MemtoReg = exQ.memtoReg;
  assign ex_RegWrite = exQ.regWrite;
  assign ex_Branch   = exQ.branch;

endmodule
